// File: rtl/sensor_acq_ctrl_pkg.sv
// rtl/sensor_acq_ctrl_pkg.sv - shared state encodings and widths for the sensor acquisition controller
package sensor_acq_ctrl_pkg;

    localparam int TEMP_W   = 5;
    localparam int BUNDLE_W = 7;
    localparam int SYNC_W   = BUNDLE_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SAMPLE = 2'b01,
        ST_VALID  = 2'b10,
        ST_ERROR  = 2'b11
    } acq_state_t;

endpackage

// File: rtl/sensor_acq_ctrl_sync.sv
// rtl/sensor_acq_ctrl_sync.sv - parameterized-width two-flop synchronizer for raw sensor inputs
module sincronizador_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sensor_acq_ctrl.sv
// rtl/sensor_acq_ctrl.sv - debounced sensor acquisition: confirm N identical samples, hold reading until ack
module sensor_acq_ctrl
    import sensor_acq_ctrl_pkg::*;
#(
    parameter int N_CONFIRM = 3,
    parameter int MAX_RETRY = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TEMP_W-1:0] Temperatura,
    input  logic              Presencia,
    input  logic              Ignicion,
    input  logic              datos_listos,
    input  logic              ack,
    output logic [TEMP_W-1:0] Temperatura_Sincronizada,
    output logic              Presencia_Sincronizada,
    output logic              Ignicion_Sincronizada,
    output logic              Dato_listo,
    output logic              Error_sensor,
    output logic              Overrun,
    output logic [1:0]        Estado_acq
);

    localparam logic [3:0] CONFIRM_W = 4'(N_CONFIRM);
    localparam logic [3:0] RETRY_W   = 4'(MAX_RETRY);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [SYNC_W-1:0]   sync_q;
    logic [BUNDLE_W-1:0] bundle;
    logic                dl_sync;
    logic                dl_d;
    logic                rise;

    acq_state_t          state;
    logic [BUNDLE_W-1:0] shadow;
    logic [3:0]          match_cnt;
    logic [3:0]          retry_cnt;
    logic [7:0]          wait_cnt;

    sincronizador_2ff #(.WIDTH(SYNC_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({datos_listos, Temperatura, Presencia, Ignicion}),
        .q   (sync_q)
    );

    assign bundle  = sync_q[BUNDLE_W-1:0];
    assign dl_sync = sync_q[SYNC_W-1];
    assign rise    = dl_sync & ~dl_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_d <= 1'b0;
        end else begin
            dl_d <= dl_sync;
        end
    end

    // Every path into SAMPLE reloads the shadow and restarts both counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                    <= ST_IDLE;
            shadow                   <= '0;
            match_cnt                <= '0;
            retry_cnt                <= '0;
            wait_cnt                 <= '0;
            Temperatura_Sincronizada <= '0;
            Presencia_Sincronizada   <= 1'b0;
            Ignicion_Sincronizada    <= 1'b0;
            Dato_listo               <= 1'b0;
            Error_sensor             <= 1'b0;
            Overrun                  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state     <= ST_SAMPLE;
                        shadow    <= bundle;
                        match_cnt <= 4'd1;
                        retry_cnt <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (bundle == shadow) begin
                        if (match_cnt + 4'd1 == CONFIRM_W) begin
                            state                    <= ST_VALID;
                            Temperatura_Sincronizada <= shadow[BUNDLE_W-1:2];
                            Presencia_Sincronizada   <= shadow[1];
                            Ignicion_Sincronizada    <= shadow[0];
                            Dato_listo               <= 1'b1;
                            Error_sensor             <= 1'b0;
                            wait_cnt                 <= '0;
                        end else begin
                            match_cnt <= match_cnt + 4'd1;
                        end
                    end else begin
                        shadow    <= bundle;
                        match_cnt <= 4'd1;
                        retry_cnt <= retry_cnt + 4'd1;
                        if (retry_cnt + 4'd1 == RETRY_W) begin
                            state        <= ST_ERROR;
                            Error_sensor <= 1'b1;
                        end
                    end
                end
                ST_VALID: begin
                    if (ack) begin
                        Dato_listo <= 1'b0;
                        Overrun    <= 1'b0;
                        wait_cnt   <= '0;
                        if (rise) begin
                            state     <= ST_SAMPLE;
                            shadow    <= bundle;
                            match_cnt <= 4'd1;
                            retry_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        if (rise) begin
                            Overrun <= 1'b1;
                        end
                        if (wait_cnt == WAIT_LAST) begin
                            state      <= ST_IDLE;
                            Dato_listo <= 1'b0;
                            Overrun    <= 1'b1;
                            wait_cnt   <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                end
                ST_ERROR: begin
                    if (rise) begin
                        state     <= ST_SAMPLE;
                        shadow    <= bundle;
                        match_cnt <= 4'd1;
                        retry_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Estado_acq = state;

endmodule

// File: tb/tb_sensor_acq_ctrl.sv
// tb/tb_sensor_acq_ctrl.sv - directed self-checking bench for sensor_acq_ctrl
module tb_sensor_acq_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] Temperatura;
    logic       Presencia;
    logic       Ignicion;
    logic       datos_listos;
    logic       ack;
    logic [4:0] Temperatura_Sincronizada;
    logic       Presencia_Sincronizada;
    logic       Ignicion_Sincronizada;
    logic       Dato_listo;
    logic       Error_sensor;
    logic       Overrun;
    logic [1:0] Estado_acq;

    int passed = 0;
    int total  = 0;

    sensor_acq_ctrl dut (
        .clk                      (clk),
        .rst                      (rst),
        .Temperatura              (Temperatura),
        .Presencia                (Presencia),
        .Ignicion                 (Ignicion),
        .datos_listos             (datos_listos),
        .ack                      (ack),
        .Temperatura_Sincronizada (Temperatura_Sincronizada),
        .Presencia_Sincronizada   (Presencia_Sincronizada),
        .Ignicion_Sincronizada    (Ignicion_Sincronizada),
        .Dato_listo               (Dato_listo),
        .Error_sensor             (Error_sensor),
        .Overrun                  (Overrun),
        .Estado_acq               (Estado_acq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Snapshot layout: temp[11:7] pres[6] ign[5] dato[4] err[3] ovr[2] state[1:0]
    function automatic logic [11:0] snap(input logic [4:0] t, input logic p, input logic i,
                                         input logic d, input logic e, input logic o,
                                         input logic [1:0] s);
        return {t, p, i, d, e, o, s};
    endfunction

    task automatic check(input string tag, input logic [11:0] expected);
        logic [11:0] observed;
        observed = snap(Temperatura_Sincronizada, Presencia_Sincronizada, Ignicion_Sincronizada,
                        Dato_listo, Error_sensor, Overrun, Estado_acq);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s observed=%03h expected=%03h", tag, observed, expected);
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b0;
        Temperatura  = 5'd0;
        Presencia    = 1'b0;
        Ignicion     = 1'b0;
        datos_listos = 1'b0;
        ack          = 1'b0;
        edge_step();
        edge_step();
        check("reset_state", snap(5'd0, 0, 0, 0, 0, 0, 2'b00));
        rst = 1'b1;
        edge_step();

        // Stable 23/1/0 reading, commit on edge 4
        Temperatura  = 5'd23;
        Presencia    = 1'b1;
        Ignicion     = 1'b0;
        datos_listos = 1'b1;
        edge_step();
        datos_listos = 1'b0;
        edge_step();
        check("basic_edge1_idle", snap(5'd0, 0, 0, 0, 0, 0, 2'b00));
        edge_step();
        check("basic_edge2_sample", snap(5'd0, 0, 0, 0, 0, 0, 2'b01));
        edge_step();
        check("basic_edge3_no_valid", snap(5'd0, 0, 0, 0, 0, 0, 2'b01));
        edge_step();
        check("basic_edge4_valid", snap(5'd23, 1, 0, 1, 0, 0, 2'b10));
        ack = 1'b1;
        edge_step();
        ack = 1'b0;
        check("basic_ack_idle", snap(5'd23, 1, 0, 0, 0, 0, 2'b00));

        // Temperature toggles 10/11 each cycle: four mismatches end in ERROR
        Temperatura  = 5'd10;
        datos_listos = 1'b1;
        for (int i = 0; i < 7; i++) begin
            edge_step();
            Temperatura = Temperatura ^ 5'd1;
            datos_listos = 1'b0;
            if (i == 5) check("toggle_still_sample", snap(5'd23, 1, 0, 0, 0, 0, 2'b01));
        end
        check("toggle_error", snap(5'd23, 1, 0, 0, 1, 0, 2'b11));
        Temperatura = 5'd12;
        edge_step();
        edge_step();
        edge_step();
        check("error_holds", snap(5'd23, 1, 0, 0, 1, 0, 2'b11));

        datos_listos = 1'b1;
        edge_step();
        datos_listos = 1'b0;
        edge_step();
        edge_step();
        edge_step();
        check("recover_edge3_err_kept", snap(5'd23, 1, 0, 0, 1, 0, 2'b01));
        edge_step();
        check("recover_commit_clears_err", snap(5'd12, 1, 0, 1, 0, 0, 2'b10));

        // No ack: reading dropped after 255 cycles in VALID
        repeat (254) edge_step();
        check("timeout_last_valid_cycle", snap(5'd12, 1, 0, 1, 0, 0, 2'b10));
        edge_step();
        check("timeout_drop", snap(5'd12, 1, 0, 0, 0, 1, 2'b00));

        // Overrun stays set through the next commit until acked
        Temperatura  = 5'd20;
        datos_listos = 1'b1;
        edge_step();
        datos_listos = 1'b0;
        repeat (4) edge_step();
        check("overrun_sticky_commit", snap(5'd20, 1, 0, 1, 0, 1, 2'b10));
        ack = 1'b1;
        edge_step();
        ack = 1'b0;
        check("overrun_cleared_by_ack", snap(5'd20, 1, 0, 0, 0, 0, 2'b00));

        Temperatura  = 5'd21;
        datos_listos = 1'b1;
        edge_step();
        datos_listos = 1'b0;
        repeat (4) edge_step();
        check("second_commit", snap(5'd21, 1, 0, 1, 0, 0, 2'b10));

        // Rise in VALID without ack
        Temperatura  = 5'd30;
        datos_listos = 1'b1;
        edge_step();
        datos_listos = 1'b0;
        edge_step();
        edge_step();
        check("rise_in_valid_overrun", snap(5'd21, 1, 0, 1, 0, 1, 2'b10));
        repeat (3) edge_step();

        // Rise coincident with ack
        datos_listos = 1'b1;
        edge_step();
        datos_listos = 1'b0;
        edge_step();
        ack = 1'b1;
        edge_step();
        ack = 1'b0;
        check("rise_with_ack_sample", snap(5'd21, 1, 0, 0, 0, 0, 2'b01));
        edge_step();
        edge_step();
        check("rise_with_ack_commit", snap(5'd30, 1, 0, 1, 0, 0, 2'b10));
        ack = 1'b1;
        edge_step();
        ack = 1'b0;
        check("ack_after_direct", snap(5'd30, 1, 0, 0, 0, 0, 2'b00));

        // Reset mid-acquisition with datos_listos held high across release
        Temperatura  = 5'd7;
        datos_listos = 1'b1;
        edge_step();
        edge_step();
        edge_step();
        check("pre_reset_sample", snap(5'd30, 1, 0, 0, 0, 0, 2'b01));
        rst = 1'b0;
        #1;
        check("reset_async_clear", snap(5'd0, 0, 0, 0, 0, 0, 2'b00));
        edge_step();
        edge_step();
        check("reset_held", snap(5'd0, 0, 0, 0, 0, 0, 2'b00));
        rst = 1'b1;
        edge_step();
        edge_step();
        edge_step();
        check("release_sample", snap(5'd0, 0, 0, 0, 0, 0, 2'b01));
        edge_step();
        check("release_no_early_valid", snap(5'd0, 0, 0, 0, 0, 0, 2'b01));
        edge_step();
        check("release_commit", snap(5'd7, 1, 0, 1, 0, 0, 2'b10));
        ack = 1'b1;
        edge_step();
        ack = 1'b0;
        repeat (5) edge_step();
        check("held_high_single_acq", snap(5'd7, 1, 0, 0, 0, 0, 2'b00));
        datos_listos = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
